// File: rtl/measure_pkg.sv
// Shared encodings and defaults for the cursor measurement sequencer.
package measure_pkg;

  localparam int unsigned NUM_W_DEF = 14;

  localparam logic [2:0] MEAS_NONE = 3'd0;
  localparam logic [2:0] MEAS_X    = 3'd1;
  localparam logic [2:0] MEAS_Y    = 3'd2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DIFF  = 2'd1;
  localparam logic [1:0] S_SCALE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  function automatic logic is_measure(input logic [2:0] mode);
    return (mode == MEAS_X) || (mode == MEAS_Y);
  endfunction

endpackage

// File: rtl/measure_refresh_timer.sv
// Free-running refresh counter: counts 0..REFRESH_CYCLES-1 and flags the wrap cycle.
module measure_refresh_timer #(
  parameter int unsigned REFRESH_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  output logic wrap
);

  localparam int unsigned CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_CYCLES - 1);

  logic [CW-1:0] count;

  assign wrap = (count == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (wrap) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/measure_sequencer.sv
// Handshaked cursor measurement: snapshot, |delta|, scale, saturate, publish.
// Optional auto-refresh requests are enabled with MEASURE_AUTO_REFRESH_EN.
module measure_sequencer
  import measure_pkg::*;
#(
  parameter int unsigned NUM_W          = NUM_W_DEF,
  parameter int unsigned REFRESH_CYCLES = 1_000_000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             measureReq,
  input  logic [2:0]       measurement,
  input  logic [1:0]       waveSel,
  input  logic [10:0]      cursorx1,
  input  logic [10:0]      cursorx2,
  input  logic [10:0]      cursory1,
  input  logic [10:0]      cursory2,
  input  logic [5:0]       sampleadjust1,
  input  logic [5:0]       sampleadjust2,
  input  logic [3:0]       shiftDown1,
  input  logic [3:0]       shiftDown2,
  output logic             measureBusy,
  output logic             measureValid,
  output logic [NUM_W-1:0] num,
  output logic             overflow
);

  localparam logic [25:0] MAXV = 26'((64'd1 << NUM_W) - 64'd1);

  logic [1:0]  state;
  logic [2:0]  snapMode;
  logic [10:0] snapA, snapB;
  logic [5:0]  snapAdj;
  logic [3:0]  snapShift;
  logic [10:0] delta;
  logic [25:0] prod;

  logic        autoReq;
  logic        req;
  logic [10:0] selA, selB;
  logic [5:0]  selAdj;
  logic [3:0]  selShift;
  logic [16:0] xprod;

`ifdef MEASURE_AUTO_REFRESH_EN
  measure_refresh_timer #(
    .REFRESH_CYCLES(REFRESH_CYCLES)
  ) u_refresh (
    .clock(clock),
    .reset(reset),
    .wrap (autoReq)
  );
`else
  // REFRESH_CYCLES is kept only so both builds share one parameter list.
  assign autoReq = 1'b0 & (REFRESH_CYCLES == 0);
`endif

  assign req         = measureReq | autoReq;
  assign measureBusy = (state != S_IDLE);
  assign xprod       = 17'(delta) * 17'(snapAdj);

  always_comb begin
    selA     = cursorx1;
    selB     = cursorx2;
    selAdj   = sampleadjust1;
    selShift = shiftDown1;
    if (measurement == MEAS_Y) begin
      selA = cursory1;
      selB = cursory2;
    end
    if (waveSel == 2'd1) begin
      selAdj   = sampleadjust2;
      selShift = shiftDown2;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      snapMode     <= MEAS_NONE;
      snapA        <= '0;
      snapB        <= '0;
      snapAdj      <= '0;
      snapShift    <= '0;
      delta        <= '0;
      prod         <= '0;
      num          <= '0;
      overflow     <= 1'b0;
      measureValid <= 1'b0;
    end else begin
      measureValid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            if (is_measure(measurement)) begin
              snapMode  <= measurement;
              snapA     <= selA;
              snapB     <= selB;
              snapAdj   <= selAdj;
              snapShift <= selShift;
              state     <= S_DIFF;
            end else begin
              num          <= '0;
              overflow     <= 1'b0;
              measureValid <= 1'b1;
            end
          end
        end
        S_DIFF: begin
          delta <= (snapA >= snapB) ? (snapA - snapB) : (snapB - snapA);
          state <= S_SCALE;
        end
        S_SCALE: begin
          if (snapMode == MEAS_X) begin
            prod <= 26'(xprod >> snapShift);
          end else begin
            prod <= 26'(delta) << snapShift;
          end
          state <= S_DONE;
        end
        default: begin
          if (prod > MAXV) begin
            num      <= NUM_W'(MAXV);
            overflow <= 1'b1;
          end else begin
            num      <= NUM_W'(prod);
            overflow <= 1'b0;
          end
          measureValid <= 1'b1;
          state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_measure_sequencer.sv
// Self-checking bench for measure_sequencer: directed table, random vs. model, corner sequences.
module tb_measure_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        measureReq;
  logic [2:0]  measurement;
  logic [1:0]  waveSel;
  logic [10:0] cursorx1, cursorx2, cursory1, cursory2;
  logic [5:0]  sampleadjust1, sampleadjust2;
  logic [3:0]  shiftDown1, shiftDown2;
  logic        measureBusy, measureValid, overflow;
  logic [13:0] num;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  measure_sequencer #(
    .NUM_W(14)
`ifdef MEASURE_AUTO_REFRESH_EN
    , .REFRESH_CYCLES(16)
`endif
  ) dut (
    .clock(clock), .reset(reset), .measureReq(measureReq),
    .measurement(measurement), .waveSel(waveSel),
    .cursorx1(cursorx1), .cursorx2(cursorx2),
    .cursory1(cursory1), .cursory2(cursory2),
    .sampleadjust1(sampleadjust1), .sampleadjust2(sampleadjust2),
    .shiftDown1(shiftDown1), .shiftDown2(shiftDown2),
    .measureBusy(measureBusy), .measureValid(measureValid),
    .num(num), .overflow(overflow)
  );

  typedef struct {
    logic [2:0]  mode;
    logic [1:0]  wsel;
    logic [10:0] x1, x2, y1, y2;
    logic [5:0]  sa1, sa2;
    logic [3:0]  sd1, sd2;
    int          enum_;
    int          eovf;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic straight from the measurement rules.
  function automatic int model_raw(input vec_t v);
    int a, b, d, sa, sd;
    sa = (v.wsel == 2'd1) ? int'(v.sa2) : int'(v.sa1);
    sd = (v.wsel == 2'd1) ? int'(v.sd2) : int'(v.sd1);
    if (v.mode == 3'd1) begin a = v.x1; b = v.x2; end
    else if (v.mode == 3'd2) begin a = v.y1; b = v.y2; end
    else return 0;
    d = (a > b) ? a - b : b - a;
    if (v.mode == 3'd1) return (d * sa) / (1 << sd);
    return d * (1 << sd);
  endfunction

  task automatic drive(input vec_t v);
    measurement   = v.mode;  waveSel       = v.wsel;
    cursorx1      = v.x1;    cursorx2      = v.x2;
    cursory1      = v.y1;    cursory2      = v.y2;
    sampleadjust1 = v.sa1;   sampleadjust2 = v.sa2;
    shiftDown1    = v.sd1;   shiftDown2    = v.sd2;
  endtask

  task automatic scramble();
    measurement   = 3'($urandom);  waveSel       = 2'($urandom);
    cursorx1      = 11'($urandom); cursorx2      = 11'($urandom);
    cursory1      = 11'($urandom); cursory2      = 11'($urandom);
    sampleadjust1 = 6'($urandom);  sampleadjust2 = 6'($urandom);
    shiftDown1    = 4'($urandom);  shiftDown2    = 4'($urandom);
  endtask

  task automatic run_meas(input string tag, input vec_t v, input bit scr);
    int lat;
    bit meas;
    meas = (v.mode == 3'd1) || (v.mode == 3'd2);
    @(negedge clock);
    drive(v);
    measureReq = 1'b1;
    @(posedge clock);
    #1 measureReq = 1'b0;
    if (!meas) begin
      chk({tag, " valid"}, int'(measureValid), 1);
      chk({tag, " busy"}, int'(measureBusy), 0);
    end else begin
      chk({tag, " busy"}, int'(measureBusy), 1);
      if (scr) scramble();
      lat = 0;
      while (!measureValid && lat < 8) begin
        @(posedge clock);
        #1 lat++;
      end
      chk({tag, " latency"}, lat, 3);
    end
    chk({tag, " num"}, int'(num), v.enum_);
    chk({tag, " ovf"}, int'(overflow), v.eovf);
    @(posedge clock);
    #1;
    chk({tag, " valid drop"}, int'(measureValid), 0);
    chk({tag, " idle"}, int'(measureBusy), 0);
  endtask

  vec_t vecs[9];
  vec_t v, v2;
  int   raw, pulses, t_last, t_now, gaps_ok;

  initial begin
    measureReq = 1'b0;
    v = '{3'd0, 2'd0, 11'd0, 11'd0, 11'd0, 11'd0, 6'd0, 6'd0, 4'd0, 4'd0, 0, 0};
    drive(v);
    reset = 1'b1;
    #1;
    chk("reset num", int'(num), 0);
    chk("reset ovf", int'(overflow), 0);
    chk("reset valid", int'(measureValid), 0);
    chk("reset busy", int'(measureBusy), 0);
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b0;

`ifdef MEASURE_AUTO_REFRESH_EN
    pulses = 0; t_last = -1; gaps_ok = 1;
    for (int c = 0; c < 70; c++) begin
      @(posedge clock);
      #1;
      if (measureValid) begin
        t_now = c;
        if (t_last >= 0 && t_now - t_last != 16) gaps_ok = 0;
        t_last = t_now;
        pulses++;
      end
    end
    chk("refresh pulses", int'(pulses >= 4), 1);
    chk("refresh period", gaps_ok, 1);
    chk("refresh num", int'(num), 0);
`else
    vecs[0] = '{3'd1, 2'd0, 11'd100, 11'd40, 11'd0, 11'd0, 6'd4, 6'd0, 4'd1, 4'd0, 120, 0};
    vecs[1] = '{3'd1, 2'd0, 11'd40, 11'd100, 11'd0, 11'd0, 6'd4, 6'd0, 4'd1, 4'd0, 120, 0};
    vecs[2] = '{3'd2, 2'd1, 11'd0, 11'd0, 11'd10, 11'd200, 6'd0, 6'd0, 4'd0, 4'd3, 1520, 0};
    vecs[3] = '{3'd2, 2'd0, 11'd0, 11'd0, 11'd0, 11'd2047, 6'd0, 6'd0, 4'd4, 4'd0, 16383, 1};
    vecs[4] = '{3'd0, 2'd0, 11'd900, 11'd1, 11'd5, 11'd600, 6'd7, 6'd7, 4'd1, 4'd1, 0, 0};
    vecs[5] = '{3'd2, 2'd0, 11'd0, 11'd0, 11'd0, 11'd2047, 6'd0, 6'd0, 4'd4, 4'd0, 16383, 1};
    vecs[6] = '{3'd5, 2'd1, 11'd900, 11'd1, 11'd5, 11'd600, 6'd7, 6'd7, 4'd1, 4'd1, 0, 0};
    vecs[7] = '{3'd1, 2'd0, 11'd500, 11'd3, 11'd0, 11'd0, 6'd0, 6'd9, 4'd0, 4'd0, 0, 0};
    vecs[8] = '{3'd1, 2'd2, 11'd10, 11'd0, 11'd0, 11'd0, 6'd3, 6'd9, 4'd0, 4'd0, 30, 0};
    for (int i = 0; i < 9; i++) run_meas($sformatf("vec%0d", i), vecs[i], 1'b0);

    // Delta of zero in Y mode after a nonzero result.
    v = '{3'd2, 2'd1, 11'd0, 11'd0, 11'd77, 11'd77, 6'd0, 6'd0, 4'd0, 4'd5, 0, 0};
    run_meas("ydelta0", vecs[2], 1'b0);
    run_meas("ydelta0b", v, 1'b0);

    for (int i = 0; i < 40; i++) begin
      v.mode = (i % 5 == 4) ? 3'($urandom_range(7, 3)) : 3'($urandom_range(2, 1));
      v.wsel = 2'($urandom);
      v.x1 = 11'($urandom); v.x2 = 11'($urandom);
      v.y1 = 11'($urandom); v.y2 = 11'($urandom);
      v.sa1 = 6'($urandom); v.sa2 = 6'($urandom);
      v.sd1 = 4'($urandom); v.sd2 = 4'($urandom);
      raw = model_raw(v);
      v.eovf  = (raw > 16383) ? 1 : 0;
      v.enum_ = (raw > 16383) ? 16383 : raw;
      run_meas($sformatf("rand%0d", i), v, 1'b1);
    end

    // Second request one clock after the first must be dropped.
    run_meas("pre-drop", vecs[2], 1'b0);
    @(negedge clock);
    drive(vecs[0]);
    measureReq = 1'b1;
    @(posedge clock);
    #1;
    v2 = vecs[3];
    @(negedge clock);
    drive(v2);
    @(posedge clock);
    #1 measureReq = 1'b0;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clock);
      #1;
      if (measureValid) pulses++;
    end
    chk("drop pulses", pulses, 1);
    chk("drop num", int'(num), 120);
    chk("drop ovf", int'(overflow), 0);

    // Reset while the pipeline is in SCALE.
    run_meas("pre-reset", vecs[2], 1'b0);
    @(negedge clock);
    drive(vecs[0]);
    measureReq = 1'b1;
    @(posedge clock);
    #1 measureReq = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("midreset num", int'(num), 0);
    chk("midreset busy", int'(measureBusy), 0);
    chk("midreset valid", int'(measureValid), 0);
    @(negedge clock) reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clock);
      #1;
      if (measureValid) pulses++;
    end
    chk("midreset no valid", pulses, 0);
    run_meas("post-reset", vecs[0], 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
